// File: rtl/sine_sched_pkg.sv
// Shared types and constants for the dual-channel sine ROM sample scheduler.
package sine_sched_pkg;

  typedef enum logic [1:0] {IDLE, RD0, RD1, CAP1} sched_state_t;

  localparam int unsigned DIV_MIN = 3;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: emits a one-cycle tick every max(div, DIV_MIN) + 1 cycles while enabled.
module sample_tick_gen
  import sine_sched_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_eff;

  // Clamping keeps the period at least as long as one full read sequence.
  always_comb begin
    div_eff = (div < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN) : div;
    tick    = en && (cnt_q == div_eff);
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sine_rom_sched.sv
// Dual-channel sample scheduler: time-multiplexes two reads of a 1-cycle-latency sine ROM per tick.
module sine_rom_sched
  import sine_sched_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PHASE_WIDTH   = 16,
  parameter int unsigned DIV_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DIV_WIDTH-1:0]     div,
  input  logic [PHASE_WIDTH-1:0]   incr0,
  input  logic [PHASE_WIDTH-1:0]   incr1,
  input  logic [ADDRESS_WIDTH-1:0] offset1,
  input  logic                     phase_clr,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  output logic [DATA_WIDTH-1:0]    dout0,
  output logic [DATA_WIDTH-1:0]    dout1,
  output logic                     valid0,
  output logic                     valid1,
  output logic                     busy
);

  sched_state_t state_q, state_d;

  logic [PHASE_WIDTH-1:0]   phase0_q, phase0_d, phase1_q, phase1_d;
  logic [PHASE_WIDTH-1:0]   incr0_s_q, incr0_s_d, incr1_s_q, incr1_s_d;
  logic [ADDRESS_WIDTH-1:0] off1_s_q, off1_s_d, rom_addr_q, rom_addr_d, ch1_addr;
  logic [DATA_WIDTH-1:0]    dout0_q, dout0_d, dout1_q, dout1_d;
  logic                     valid0_q, valid0_d, valid1_q, valid1_d;
  logic                     clr_pend_q, clr_pend_d;
  logic                     tick;

  sample_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    phase0_d   = phase0_q;
    phase1_d   = phase1_q;
    incr0_s_d  = incr0_s_q;
    incr1_s_d  = incr1_s_q;
    off1_s_d   = off1_s_q;
    rom_addr_d = rom_addr_q;
    dout0_d    = dout0_q;
    dout1_d    = dout1_q;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    clr_pend_d = clr_pend_q;
    ch1_addr   = phase1_q[PHASE_WIDTH-1 -: ADDRESS_WIDTH] + off1_s_q;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          rom_addr_d = phase0_q[PHASE_WIDTH-1 -: ADDRESS_WIDTH];
          incr0_s_d  = incr0;
          incr1_s_d  = incr1;
          off1_s_d   = offset1;
          clr_pend_d = phase_clr;
          state_d    = RD0;
        end else if (phase_clr) begin
          phase0_d = '0;
          phase1_d = '0;
        end
      end
      RD0: begin
        rom_addr_d = ch1_addr;
        clr_pend_d = clr_pend_q | phase_clr;
        state_d    = RD1;
      end
      RD1: begin
        dout0_d    = rom_dout;
        valid0_d   = 1'b1;
        clr_pend_d = clr_pend_q | phase_clr;
        state_d    = CAP1;
      end
      CAP1: begin
        dout1_d  = rom_dout;
        valid1_d = 1'b1;
        // A clear requested on this very edge is honoured here rather than carried over.
        if (clr_pend_q || phase_clr) begin
          phase0_d = '0;
          phase1_d = '0;
        end else begin
          phase0_d = phase0_q + incr0_s_q;
          phase1_d = phase1_q + incr1_s_q;
        end
        clr_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase0_q   <= '0;
      phase1_q   <= '0;
      incr0_s_q  <= '0;
      incr1_s_q  <= '0;
      off1_s_q   <= '0;
      rom_addr_q <= '0;
      dout0_q    <= '0;
      dout1_q    <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase0_q   <= phase0_d;
      phase1_q   <= phase1_d;
      incr0_s_q  <= incr0_s_d;
      incr1_s_q  <= incr1_s_d;
      off1_s_q   <= off1_s_d;
      rom_addr_q <= rom_addr_d;
      dout0_q    <= dout0_d;
      dout1_q    <= dout1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign dout0    = dout0_q;
  assign dout1    = dout1_q;
  assign valid0   = valid0_q;
  assign valid1   = valid1_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sine_rom_sched.sv
// Self-checking bench for sine_rom_sched: identity ROM, vector table, corner sequences, random run.
module tb_sine_rom_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        phase_clr = 1'b0;
  logic [15:0] div = 16'd9;
  logic [15:0] incr0 = '0;
  logic [15:0] incr1 = '0;
  logic [7:0]  offset1 = '0;
  logic [7:0]  rom_addr, rom_dout, dout0, dout1;
  logic        valid0, valid1, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Identity ROM with registered output.
  always_ff @(posedge clk) rom_dout <= rom_addr;

  sine_rom_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div      (div),
    .incr0    (incr0),
    .incr1    (incr1),
    .offset1  (offset1),
    .phase_clr(phase_clr),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .dout0    (dout0),
    .dout1    (dout1),
    .valid0   (valid0),
    .valid1   (valid1),
    .busy     (busy)
  );

  // Reference model: a sample timeline, age = edges since the tick edge (-1 when idle).
  logic [15:0] m_cnt, m_ph0, m_ph1, m_inc0, m_inc1;
  logic [7:0]  m_e0, m_e1, m_addr, m_d0, m_d1;
  logic        m_v0, m_v1, m_pend;
  int          m_age;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_ph0 = '0; m_ph1 = '0; m_inc0 = '0; m_inc1 = '0;
    m_e0 = '0; m_e1 = '0; m_addr = '0; m_d0 = '0; m_d1 = '0;
    m_v0 = 1'b0; m_v1 = 1'b0; m_pend = 1'b0; m_age = -1;
  endtask

  task automatic model_edge();
    logic [15:0] div_eff;
    logic        tick;
    if (!rst_n) begin
      model_reset();
    end else begin
      div_eff = (div < 16'd3) ? 16'd3 : div;
      tick    = en && (m_cnt == div_eff);
      m_cnt   = (!en || tick) ? 16'd0 : m_cnt + 16'd1;
      m_v0    = 1'b0;
      m_v1    = 1'b0;
      if (m_age < 0) begin
        if (tick) begin
          m_e0   = m_ph0[15:8];
          m_e1   = m_ph1[15:8] + offset1;
          m_inc0 = incr0;
          m_inc1 = incr1;
          m_addr = m_e0;
          m_pend = phase_clr;
          m_age  = 0;
        end else if (phase_clr) begin
          m_ph0 = '0;
          m_ph1 = '0;
        end
      end else begin
        m_age++;
        if (m_age == 1) m_addr = m_e1;
        if (m_age == 2) begin
          m_d0 = m_e0;
          m_v0 = 1'b1;
        end
        if (m_age == 3) begin
          m_d1 = m_e1;
          m_v1 = 1'b1;
          if (m_pend || phase_clr) begin
            m_ph0 = '0;
            m_ph1 = '0;
          end else begin
            m_ph0 = m_ph0 + m_inc0;
            m_ph1 = m_ph1 + m_inc1;
          end
          m_pend = 1'b0;
          m_age  = -1;
        end else if (phase_clr) begin
          m_pend = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", busy, m_age >= 0);
    chk("valid0", valid0, m_v0);
    chk("valid1", valid1, m_v1);
    chk("dout0", dout0, m_d0);
    chk("dout1", dout1, m_d1);
    chk("rom_addr", rom_addr, m_addr);
    chk("valid_excl", valid0 & valid1, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_v0"}, valid0, 0);
    chk({tag, "_v1"}, valid1, 0);
    chk({tag, "_d0"}, dout0, 0);
    chk({tag, "_d1"}, dout1, 0);
    chk({tag, "_addr"}, rom_addr, 0);
  endtask

  task automatic do_reset();
    en = 1'b0;
    phase_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("reset");
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_age(input int a, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = (m_age == a);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no state match expected age %0d", nm, a);
    end
  endtask

  task automatic next_sample(output logic [7:0] d0, output logic [7:0] d1, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = valid1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no valid1 expected one within 200 cycles", nm);
    end
    d0 = dout0;
    d1 = dout1;
  endtask

  typedef struct {
    logic [15:0] div;
    logic [15:0] incr0;
    logic [15:0] incr1;
    logic [7:0]  off;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          period;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] d0, d1;
    int n0, n1, nb, prev_v0, last_v0, last_v1;
    bit done;

    vecs[0] = '{16'd9, 16'h0100, 16'h0100, 8'h40, 3, 8'h02, 8'h42, 10};
    vecs[1] = '{16'd0, 16'h0100, 16'h0300, 8'h00, 4, 8'h03, 8'h09, 4};
    vecs[2] = '{16'd7, 16'h8000, 16'h0800, 8'hF0, 5, 8'h00, 8'h10, 8};
    vecs[3] = '{16'd5, 16'h8000, 16'h0000, 8'h7F, 2, 8'h80, 8'h7F, 6};
    vecs[4] = '{16'd2, 16'h0155, 16'hFFFF, 8'h01, 3, 8'h02, 8'h00, 4};

    model_reset();
    do_reset();

    foreach (vecs[k]) begin
      do_reset();
      div = vecs[k].div; incr0 = vecs[k].incr0; incr1 = vecs[k].incr1; offset1 = vecs[k].off;
      en = 1'b1;
      n1 = 0; prev_v0 = 0; last_v0 = 0; last_v1 = 0; done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
        step();
        if (valid0) begin
          prev_v0 = last_v0;
          last_v0 = cyc;
        end
        if (valid1) begin
          n1++;
          last_v1 = cyc;
          if (n1 == vecs[k].n) begin
            done = 1'b1;
            chk("vec_d0", dout0, vecs[k].d0);
            chk("vec_d1", dout1, vecs[k].d1);
            chk("vec_period", last_v0 - prev_v0, vecs[k].period);
            chk("vec_v0_to_v1", last_v1 - last_v0, 1);
          end
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL vec%0d timeout: got %0d samples expected %0d", k, n1, vecs[k].n);
      end
    end

    // Clear requested mid-sample: in-flight sample keeps old phase, next starts from zero.
    do_reset();
    div = 16'd9; incr0 = 16'h0100; incr1 = 16'h0100; offset1 = 8'h33; en = 1'b1;
    for (int s = 0; s < 5; s++) next_sample(d0, d1, "t4_pre");
    wait_age(1, "t4_rd1");
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    next_sample(d0, d1, "t4_cur");
    chk("t4_cur_d0", d0, 8'h05);
    chk("t4_cur_d1", d1, 8'h38);
    next_sample(d0, d1, "t4_next");
    chk("t4_next_d0", d0, 8'h00);
    chk("t4_next_d1", d1, 8'h33);

    // Enable dropped in RD0: the sample completes, then silence; restart after div_eff+1.
    do_reset();
    div = 16'd5; incr0 = 16'h0100; incr1 = 16'h0040; offset1 = 8'h10; en = 1'b1;
    wait_age(0, "t5_rd0");
    en = 1'b0;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n0 += int'(valid0);
      n1 += int'(valid1);
    end
    chk("t5_v0_count", n0, 1);
    chk("t5_v1_count", n1, 1);
    en = 1'b1;
    nb = 0; done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      nb++;
      done = busy;
    end
    chk("t5_restart", nb, 6);

    // Reset asserted in CAP1: outputs clear without waiting for an edge; phases restart.
    do_reset();
    div = 16'd4; incr0 = 16'h0100; incr1 = 16'h0100; offset1 = 8'h20; en = 1'b1;
    for (int s = 0; s < 3; s++) next_sample(d0, d1, "t6_pre");
    wait_age(2, "t6_cap1");
    chk("t6_pre_d0", dout0, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    en = 1'b1;
    next_sample(d0, d1, "t6_post");
    chk("t6_post_d0", d0, 8'h00);
    chk("t6_post_d1", d1, 8'h20);

    // Randomised run against the model, including shadow-register input churn.
    do_reset();
    div = 16'd3; en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      incr0 = 16'($urandom);
      incr1 = 16'($urandom);
      offset1 = 8'($urandom);
      phase_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) en = ~en;
      if (!en) div = 16'($urandom_range(0, 8));
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
